// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the rv32im inter-stage pipeline registers:
// occupancy-state encoding and the payload widths of each stage boundary.
package rv_pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned IFID_W   = 3 * XLEN;          // pc, pc+4, instruction
  localparam int unsigned IDEX_W   = 4 * XLEN + 32;     // pc, rs1, rs2, imm, control word
  localparam int unsigned EXMEM_W  = 3 * XLEN + 8;      // pc+4, alu result, store data, control
  localparam int unsigned MEMWB_W  = 2 * XLEN + 8;      // result, pc+4, writeback control

  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_ONE   = ST_ONE,
    S_TWO   = ST_TWO
  } pipe_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
  } ifid_payload_t;

  function automatic logic [1:0] occ_of(input pipe_state_e st);
    logic [1:0] occ;
    case (st)
      S_EMPTY: occ = 2'd0;
      S_ONE:   occ = 2'd1;
      S_TWO:   occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_entry.sv
// One payload slot of a pipeline stage: loads, clears to the bubble value,
// or holds. Clear wins over load so a kill never lets a new entry slip in.
module pipe_stage_entry #(
  parameter int unsigned         DATA_W     = 96,
  parameter logic [DATA_W-1:0]   BUBBLE_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  // Next-value selection: clear, load or hold.
  always_comb begin
    data_d = data_q;
    if (clear_i) begin
      data_d = BUBBLE_VAL;
    end else if (load_i) begin
      data_d = d_i;
    end else begin
      data_d = data_q;
    end
  end

  // Payload storage.
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush-to-bubble,
// clock-enable freeze and an optional skid entry that keeps in_ready registered.
module pipe_stage_reg
  import rv_pipe_pkg::*;
#(
  parameter int unsigned       DATA_W     = IFID_W,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
  parameter bit                SKID_EN    = 1'b1
) (
  input  logic              PS_clk,
  input  logic              PS_rst,
  input  logic              PS_ce,
  input  logic              PS_flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  pipe_state_e       state_q;
  pipe_state_e       state_d;
  logic              out_valid_q;
  logic [1:0]        occ_q;

  logic              in_ready_s;
  logic              in_fire_s;
  logic              out_fire_s;

  logic              main_load_s;
  logic              main_clear_s;
  logic              main_from_skid_s;
  logic              skid_load_s;
  logic              skid_clear_s;
  logic [DATA_W-1:0] main_d_s;
  logic [DATA_W-1:0] main_q_s;
  logic [DATA_W-1:0] skid_q_s;

  // Upstream ready: registered-only in skid mode, pass-through of out_ready otherwise.
  always_comb begin
    in_ready_s = 1'b0;
    if (SKID_EN) begin
      in_ready_s = PS_ce & ~PS_rst & (state_q != S_TWO);
    end else begin
      in_ready_s = PS_ce & ~PS_rst & (~out_valid_q | out_ready);
    end
  end

  assign in_fire_s  = in_valid & in_ready_s;
  assign out_fire_s = out_valid_q & out_ready & PS_ce;

  // Occupancy FSM and slot controls; reset and flush dominate the freeze.
  always_comb begin
    state_d          = state_q;
    main_load_s      = 1'b0;
    main_clear_s     = 1'b0;
    main_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    skid_clear_s     = 1'b0;
    if (PS_rst || PS_flush) begin
      state_d      = S_EMPTY;
      main_clear_s = 1'b1;
      skid_clear_s = 1'b1;
    end else if (!PS_ce) begin
      state_d = state_q;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire_s) begin
            state_d     = S_ONE;
            main_load_s = 1'b1;
          end else begin
            state_d = S_EMPTY;
          end
        end
        S_ONE: begin
          if (in_fire_s && out_fire_s) begin
            state_d     = S_ONE;
            main_load_s = 1'b1;
          end else if (in_fire_s) begin
            // Without a skid slot this arm is unreachable: in_ready implies out_fire.
            if (SKID_EN) begin
              state_d     = S_TWO;
              skid_load_s = 1'b1;
            end else begin
              state_d = S_ONE;
            end
          end else if (out_fire_s) begin
            state_d      = S_EMPTY;
            main_clear_s = 1'b1;
          end else begin
            state_d = S_ONE;
          end
        end
        S_TWO: begin
          if (out_fire_s) begin
            state_d          = S_ONE;
            main_load_s      = 1'b1;
            main_from_skid_s = 1'b1;
            skid_clear_s     = 1'b1;
          end else begin
            state_d = S_TWO;
          end
        end
        default: begin
          state_d      = S_EMPTY;
          main_clear_s = 1'b1;
          skid_clear_s = 1'b1;
        end
      endcase
    end
  end

  // State and registered status outputs.
  always_ff @(posedge PS_clk) begin
    if (PS_rst) begin
      state_q     <= S_EMPTY;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d != S_EMPTY);
      occ_q       <= occ_of(state_d);
    end
  end

  assign main_d_s = main_from_skid_s ? skid_q_s : in_data;

  pipe_stage_entry #(
    .DATA_W     (DATA_W),
    .BUBBLE_VAL (BUBBLE_VAL)
  ) u_main (
    .clk_i   (PS_clk),
    .load_i  (main_load_s),
    .clear_i (main_clear_s),
    .d_i     (main_d_s),
    .q_o     (main_q_s)
  );

  generate
    if (SKID_EN) begin : g_skid
      pipe_stage_entry #(
        .DATA_W     (DATA_W),
        .BUBBLE_VAL (BUBBLE_VAL)
      ) u_skid (
        .clk_i   (PS_clk),
        .load_i  (skid_load_s),
        .clear_i (skid_clear_s),
        .d_i     (in_data),
        .q_o     (skid_q_s)
      );
    end else begin : g_no_skid
      logic unused_skid_ctrl_s;
      assign unused_skid_ctrl_s = skid_load_s ^ skid_clear_s;
      assign skid_q_s           = BUBBLE_VAL;
    end
  endgenerate

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_data  = main_q_s;
  assign occ       = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid and a single-entry instance share stimulus
// and are compared every cycle against queue models, plus directed literal checks.
module tb_pipe_stage_reg;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         ce;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;

  logic         s_in_ready, s_out_valid;
  logic [W-1:0] s_out_data;
  logic [1:0]   s_occ;
  logic         n_in_ready, n_out_valid;
  logic [W-1:0] n_out_data;
  logic [1:0]   n_occ;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  logic [W-1:0] qs[$];
  logic [W-1:0] qn[$];

  pipe_stage_reg #(.DATA_W(W), .BUBBLE_VAL(32'h0), .SKID_EN(1'b1)) u_skid (
    .PS_clk(clk), .PS_rst(rst), .PS_ce(ce), .PS_flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .occ(s_occ)
  );

  pipe_stage_reg #(.DATA_W(W), .BUBBLE_VAL(32'h0), .SKID_EN(1'b0)) u_noskid (
    .PS_clk(clk), .PS_rst(rst), .PS_ce(ce), .PS_flush(flush),
    .in_valid(in_valid), .in_ready(n_in_ready), .in_data(in_data),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
    .occ(n_occ)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Expected upstream ready from the model's occupancy and the live inputs.
  function automatic logic exp_ready(input bit skid, input int size);
    if (skid) return ce & ~rst & (size < 2);
    else      return ce & ~rst & ((size == 0) | out_ready);
  endfunction

  // Reference model: each stage is a bounded FIFO queue.
  always @(posedge clk) begin : model
    bit rs, rn;
    rs = exp_ready(1'b1, qs.size());
    rn = exp_ready(1'b0, qn.size());
    if (rst || flush) begin
      qs.delete();
      qn.delete();
    end else if (ce) begin
      if (qs.size() > 0 && out_ready) void'(qs.pop_front());
      if (in_valid && rs) qs.push_back(in_data);
      if (qn.size() > 0 && out_ready) void'(qn.pop_front());
      if (in_valid && rn) qn.push_back(in_data);
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("s.out_valid", W'(s_out_valid), W'(qs.size() > 0));
      check("s.out_data",  s_out_data, (qs.size() > 0) ? qs[0] : 32'h0);
      check("s.occ",       W'(s_occ), W'(qs.size()));
      check("s.in_ready",  W'(s_in_ready), W'(exp_ready(1'b1, qs.size())));
      check("n.out_valid", W'(n_out_valid), W'(qn.size() > 0));
      check("n.out_data",  n_out_data, (qn.size() > 0) ? qn[0] : 32'h0);
      check("n.occ",       W'(n_occ), W'(qn.size()));
      check("n.in_ready",  W'(n_in_ready), W'(exp_ready(1'b0, qn.size())));
    end
  end

  task automatic drive(input logic r, input logic c, input logic f,
                       input logic v, input logic [W-1:0] d, input logic ordy);
    rst = r; ce = c; flush = f; in_valid = v; in_data = d; out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    repeat (3) tick();
  endtask

  initial begin
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hAAA, 1'b1);
    #1;
    check("rst.ready0", W'(s_in_ready), 32'h0);
    tick();
    chk_en = 1'b1;
    check("rst.ready1", W'(s_in_ready), 32'h0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    check("rst.valid", W'(s_out_valid), 32'h0);
    check("rst.data",  s_out_data, 32'h0);
    check("rst.occ",   W'(s_occ), 32'h0);
    check("rst.ready_after", W'(s_in_ready), 32'h1);

    // Streaming at full rate.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1); tick();
    check("stream.d0", s_out_data, 32'h100);
    check("stream.occ0", W'(s_occ), 32'h1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h104, 1'b1); tick();
    check("stream.d1", s_out_data, 32'h104);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h108, 1'b1); tick();
    check("stream.d2", s_out_data, 32'h108);
    check("stream.n_d2", n_out_data, 32'h108);
    check("stream.occ2", W'(s_occ), 32'h1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1); tick();
    check("stream.empty", W'(s_out_valid), 32'h0);

    // Stall into the skid slot, then release.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0); tick();
    check("stall.occ1", W'(s_occ), 32'h1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h204, 1'b0); tick();
    check("stall.occ2", W'(s_occ), 32'h2);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h208, 1'b0); #1;
    check("stall.ready", W'(s_in_ready), 32'h0);
    tick();
    check("stall.hold", s_out_data, 32'h200);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h208, 1'b1); tick();
    check("stall.out1", s_out_data, 32'h204);
    tick();
    check("stall.out2", s_out_data, 32'h208);
    check("stall.valid2", W'(s_out_valid), 32'h1);
    drain();

    // Flush from the two-entry state.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h304, 1'b0); tick();
    check("flush.pre_occ", W'(s_occ), 32'h2);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h308, 1'b0); tick();
    check("flush.valid", W'(s_out_valid), 32'h0);
    check("flush.data",  s_out_data, 32'h0);
    check("flush.occ",   W'(s_occ), 32'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1); tick();
    check("flush.no308", W'(s_out_valid), 32'h0);

    // Freeze with a held entry.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h400, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h404, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("freeze.ready", W'(s_in_ready), 32'h0);
      tick();
      check("freeze.data", s_out_data, 32'h400);
      check("freeze.occ",  W'(s_occ), 32'h1);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1); tick();
    check("freeze.leave", W'(s_out_valid), 32'h0);

    // Single-entry back-pressure: in_ready follows out_ready.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h500, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h504, 1'b0); #1;
    check("bp.ready0", W'(n_in_ready), 32'h0);
    tick();
    check("bp.hold", n_out_data, 32'h500);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h504, 1'b1); #1;
    check("bp.ready1", W'(n_in_ready), 32'h1);
    tick();
    check("bp.load", n_out_data, 32'h504);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h504, 1'b0); #1;
    check("bp.ready2", W'(n_in_ready), 32'h0);
    tick();
    drain();

    // Randomized traffic: a congested phase then a mostly-flowing phase.
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 1500; i++) begin
        drive(($urandom % 100) == 0,
              ($urandom % 10) != 0,
              ($urandom % 33) == 0,
              ($urandom % 4) != 0,
              $urandom,
              ($urandom % 10) < ((ph == 0) ? 3 : 8));
        tick();
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the rv32im core. It generalises the fixed IF/ID buffer to any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) and carries an opaque DATA_W payload. It adds a valid/ready handshake, flush-to-bubble, a clock-enable freeze and an optional skid entry. With the skid entry, upstream ready is registered and a stall never costs a cycle of throughput.

Parameters:
DATA_W, 96, payload width in bits (default = PC + PC+4 + instruction).
BUBBLE_VAL, {DATA_W{1'b0}}, payload value presented whenever the stage holds no valid entry.
SKID_EN, 1, 1 = two-entry (main + skid) with registered in_ready; 0 = single entry with combinational ready pass-through.

Ports:
PS_clk  in  1  stage clock, rising edge.
PS_rst  in  1  synchronous active-high reset.
PS_ce  in  1  stage enable; 0 freezes all state and blocks both handshakes.
PS_flush  in  1  kill all held and incoming entries (branch/trap redirect).
in_valid  in  1  upstream entry valid.
in_ready  out  1  stage can accept this cycle.
in_data  in  DATA_W  upstream payload.
out_valid  out  1  main entry valid.
out_ready  in  1  downstream accepts.
out_data  out  DATA_W  main entry payload.
occ  out  2  number of held entries (0..2; max 1 when SKID_EN=0).

Behaviour:
- One clock, PS_clk. Reset is synchronous and active-high on PS_rst.
- Fire conditions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready & PS_ce.
- Priority order: PS_rst > PS_flush > PS_ce=0 > normal operation.
- Reset (sampled at a PS_clk edge, regardless of PS_ce or PS_flush):
  - Next cycle: state EMPTY, out_valid=0, out_data=BUBBLE_VAL, occ=0.
  - Skid register = BUBBLE_VAL.
  - in_ready=0 while PS_rst is high.
- Flush (PS_flush=1 at an edge, acts even when PS_ce=0):
  - Next cycle: state EMPTY, both registers = BUBBLE_VAL, occ=0.
  - An in_fire in the same cycle is consumed and dropped.
  - out_fire in the flush cycle still completes downstream; the entry is not replayed.
- PS_ce=0: in_ready=0, out_fire suppressed, registers hold. out_valid and out_data keep showing the held entry.
- Invariant: out_data == BUBBLE_VAL whenever out_valid=0.
- Latency: one cycle from in_fire to out_valid=1 in EMPTY. Throughput: one entry per cycle.
- SKID_EN=0 (states EMPTY, FULL):
  - in_ready = PS_ce & ~PS_rst & (~out_valid | out_ready). This is a combinational path from out_ready.
  - EMPTY + in_fire -> FULL, main<=in_data.
  - FULL + out_fire + in_fire -> FULL, main<=in_data.
  - FULL + out_fire only -> EMPTY, main<=BUBBLE_VAL.
  - FULL, no out_fire -> hold.
- SKID_EN=1 (states EMPTY, ONE, TWO):
  - in_ready = PS_ce & ~PS_rst & (state != TWO). No path from out_ready.
  - EMPTY + in_fire -> ONE, main<=in.
  - ONE + in_fire + out_fire -> ONE, main<=in.
  - ONE + in_fire only -> TWO, skid<=in.
  - ONE + out_fire only -> EMPTY, main<=BUBBLE_VAL.
  - TWO + out_fire -> ONE, main<=skid, skid<=BUBBLE_VAL.
  - TWO, no out_fire -> hold.
  - Ordering is FIFO: the skid entry always leaves after the main entry.
- occ is a registered encoding of state: EMPTY=0, ONE/FULL=1, TWO=2.
- X-safety: in_data is not captured unless in_fire=1. out_data never depends on in_data combinationally.

Decomposition:
- Shared package rv_pipe_pkg:
  - state encoding localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2.
  - stage payload width constants IFID_W=96, IDEX_W, EXMEM_W, MEMWB_W.
- One natural sub-module: pipe_stage_entry. It is a DATA_W register with load, clear-to-BUBBLE_VAL and hold controls. It is instanced for main and, under SKID_EN, for skid. The FSM and handshake logic stay in the parent.

Test Plan:
- Reset: assert PS_rst 2 cycles with in_valid=1, in_data=0xAAA.
  -> out_valid=0, out_data=0, occ=0, in_ready=0 during reset, in_ready=1 the cycle after release.
- Streaming: out_ready=1, feed 0x100,0x104,0x108 on consecutive cycles.
  -> the same values on out_data cycles 1..3 with out_valid=1 and occ never above 1.
- Stall (SKID_EN=1):
  - Feed 0x200,0x204,0x208 with out_ready=0 from cycle 1. -> occ goes 1 then 2; in_ready=0 after 0x204 is held; 0x208 is not accepted.
  - Raise out_ready. -> outputs 0x200, 0x204, 0x208 in order, no gaps.
- Flush: state TWO holding 0x300/0x304; assert PS_flush with in_valid=1, in_data=0x308.
  -> next cycle out_valid=0, out_data=0, occ=0; 0x308 never appears at the output.
- Freeze: FULL holding 0x400; PS_ce=0 for 3 cycles with out_ready=1, in_valid=1.
  -> out_data stays 0x400 with out_valid=1, in_ready=0, no entry consumed; on PS_ce=1, 0x400 leaves in one cycle.
- SKID_EN=0 back-pressure: FULL holding 0x500; toggle out_ready 0/1 with in_valid=1, in_data=0x504.
  -> in_ready mirrors out_ready in the same cycle; 0x504 loads exactly on the out_fire edge.
